// File: rtl/hex_scan_display.sv
// Multi-digit hex seven-segment scanner: latches a DIGITS-nibble value and
// time-multiplexes it onto one segment bus with leading-zero blanking and blink.
module hex_scan_display #(
  parameter int DIGITS      = 4,
  parameter int PRESCALE    = 50000,
  parameter int BLINK_SCANS = 25,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic                  blink_en,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  frame_tick
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(PRESCALE);
  localparam int BW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
  localparam logic AL = (ACTIVE_LOW != 0);
  localparam logic [6:0]        SEG_OFF = AL ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] SEL_OFF = AL ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [4*DIGITS-1:0] shadow;
  logic [4*DIGITS-1:0] shadow_eff;
  logic [CW-1:0]       pcnt;
  logic [IW-1:0]       idx;
  logic [BW-1:0]       bcnt;
  logic                phase_vis;
  logic                wrap_pend;
  logic                slot_end;
  logic                scan_end;
  logic [3:0]          nib;
  logic                dark_lz;
  logic                allz;
  logic [6:0]          pat;
  logic [6:0]          seg_nxt;
  logic [DIGITS-1:0]   sel_act;
  logic [DIGITS-1:0]   sel_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  assign slot_end = (pcnt == CW'(PRESCALE - 1));
  assign scan_end = slot_end && (idx == IW'(DIGITS - 1));

  // A load is bypassed into the decode so it shows on the very next output cycle.
  always_comb begin
    shadow_eff = load ? value : shadow;
    nib        = 4'h0;
    dark_lz    = 1'b0;
    allz       = 1'b1;
    sel_act    = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      allz = allz && (shadow_eff[4*i +: 4] == 4'h0);
      sel_act[i] = (idx == IW'(i));
      if (idx == IW'(i)) begin
        nib     = shadow_eff[4*i +: 4];
        dark_lz = allz && (i != 0);
      end
    end
    pat = hex7(nib);
    if ((blank_lz && dark_lz) || (blink_en && !phase_vis)) pat = 7'h00;
    seg_nxt = AL ? ~pat : pat;
    sel_nxt = AL ? ~sel_act : sel_act;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shadow     <= '0;
      pcnt       <= '0;
      idx        <= '0;
      bcnt       <= '0;
      phase_vis  <= 1'b1;
      wrap_pend  <= 1'b0;
      seg        <= SEG_OFF;
      digit_sel  <= SEL_OFF;
      frame_tick <= 1'b0;
    end else begin
      if (load) shadow <= value;
      pcnt <= slot_end ? '0 : pcnt + 1'b1;
      if (slot_end) idx <= scan_end ? '0 : idx + 1'b1;
      if (scan_end) begin
        if (bcnt == BW'(BLINK_SCANS - 1)) begin
          bcnt      <= '0;
          phase_vis <= ~phase_vis;
        end else begin
          bcnt <= bcnt + 1'b1;
        end
      end
      // Tick is delayed one cycle so it lines up with digit 0's first output cycle.
      wrap_pend  <= scan_end;
      seg        <= seg_nxt;
      digit_sel  <= sel_nxt;
      frame_tick <= wrap_pend;
    end
  end

endmodule

// File: tb/tb_hex_scan_display.sv
// Scoreboard bench for hex_scan_display (DIGITS=4, PRESCALE=4, BLINK_SCANS=2, active-low).
module tb_hex_scan_display;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = 16'h0000;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic        blink_en = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  digit_sel;
  logic        frame_tick;

  always #5 clock = ~clock;

  hex_scan_display #(
    .DIGITS(4), .PRESCALE(4), .BLINK_SCANS(2), .ACTIVE_LOW(1)
  ) dut (
    .clock(clock), .reset(reset), .value(value), .load(load),
    .blank_lz(blank_lz), .blink_en(blink_en),
    .seg(seg), .digit_sel(digit_sel), .frame_tick(frame_tick)
  );

  typedef struct {
    int         due;
    logic [6:0] s;
    logic [3:0] d;
    logic       t;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   j = 0;
  logic done = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      total++;
      if (e.due != cyc || seg !== e.s || digit_sel !== e.d || frame_tick !== e.t) begin
        bad++;
        $display("FAIL %s cyc=%0d got seg=%h sel=%b tick=%b want seg=%h sel=%b tick=%b",
                 e.nm, cyc, seg, digit_sel, frame_tick, e.s, e.d, e.t);
      end
    end
    if (done) begin
      if (sb.size() != 0) begin
        bad++;
        $display("FAIL drain got %0d pending entries want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  task automatic drive(input logic r, input logic ld, input logic [15:0] v,
                       input logic blz, input logic bke, input logic [6:0] es,
                       input logic [3:0] ed, input logic et, input string nm);
    exp_t e;
    reset = r; load = ld; value = v; blank_lz = blz; blink_en = bke;
    e.due = cyc + 1; e.s = es; e.d = ed; e.t = et; e.nm = nm;
    sb.push_back(e);
    @(posedge clock);
    #1;
  endtask

  // tab = {digit3, digit2, digit1, digit0} segment codes for the visible phase.
  task automatic run(input int n, input logic ld0, input logic [15:0] v,
                     input logic blz, input logic bke, input logic [27:0] tab,
                     input string nm);
    for (int k = 0; k < n; k++) begin
      int         dg;
      logic       hid;
      logic [6:0] es;
      logic [3:0] ed;
      logic       et;
      dg  = (j >> 2) & 3;
      hid = (((j >> 5) & 1) == 1) && bke;
      es  = hid ? 7'h7F : tab[7*dg +: 7];
      ed  = ~(4'(1) << dg);
      et  = ((j % 16) == 0) && (j > 0);
      drive(1'b0, ld0 && (k == 0), v, blz, bke, es, ed, et, nm);
      j++;
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 7'h7F, 4'hF, 1'b0, "reset");
    run(32, 1'b1, 16'h1234, 1'b0, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, "scan1234");
    run(16, 1'b1, 16'h0050, 1'b1, 1'b0, {7'h7F, 7'h7F, 7'h12, 7'h40}, "lz0050");
    run(16, 1'b1, 16'h0000, 1'b1, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h40}, "lz0000");
    run(16, 1'b0, 16'h0000, 1'b0, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}, "nolz0000");
    run(80, 1'b1, 16'hFA00, 1'b0, 1'b1, {7'h0E, 7'h08, 7'h40, 7'h40}, "blink");
    run(4,  1'b0, 16'hFA00, 1'b0, 1'b0, {7'h0E, 7'h08, 7'h40, 7'h40}, "pre_mid");
    run(2,  1'b1, 16'hFA00, 1'b0, 1'b0, {7'h0E, 7'h08, 7'h40, 7'h40}, "mid_fa00");
    run(10, 1'b1, 16'h1234, 1'b0, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, "mid_1234");
    run(9,  1'b0, 16'h1234, 1'b0, 1'b1, {7'h79, 7'h24, 7'h30, 7'h19}, "hidden");
    for (int k = 0; k < 2; k++) drive(1'b1, 1'b0, 16'h1234, 1'b0, 1'b1, 7'h7F, 4'hF, 1'b0, "midrst");
    j = 0;
    run(20, 1'b0, 16'h1234, 1'b0, 1'b1, {7'h40, 7'h40, 7'h40, 7'h40}, "restart");
    done = 1'b1;
    repeat (5) @(posedge clock);
    $display("FAIL monitor got no summary want summary within 5 cycles");
    $fatal(1);
  end

endmodule
